// File: rtl/hub75_pkg.sv
// Shared HUB75 constants and line-buffer address layout, used by both the
// panel-side shifter and the receive front end (hub75_rx).
package hub75_pkg;

    localparam int N_BANKS  = 2;
    localparam int N_ROWS   = 32;
    localparam int N_COLS   = 64;
    localparam int N_CHANS  = 3;
    localparam int N_PLANES = 8;

    localparam int SDW          = N_BANKS * N_CHANS;
    localparam int LOG_N_ROWS   = $clog2(N_ROWS);
    localparam int LOG_N_COLS   = $clog2(N_COLS);
    localparam int LOG_N_PLANES = $clog2(N_PLANES);

    // Line-buffer write address: buffer select sits above the column index.
    localparam int WR_ADDR_W   = 1 + LOG_N_COLS;
    localparam int BUF_SEL_BIT = LOG_N_COLS;

    typedef logic [WR_ADDR_W-1:0]    wr_addr_t;
    typedef logic [LOG_N_COLS:0]     col_cnt_t;
    typedef logic [LOG_N_PLANES-1:0] plane_t;
    typedef logic [LOG_N_ROWS-1:0]   row_t;
    typedef logic [SDW-1:0]          sdata_t;

    function automatic wr_addr_t make_wr_addr(input logic buf_sel, input logic [LOG_N_COLS-1:0] col);
        return {buf_sel, col};
    endfunction

endpackage

// File: rtl/hub75_rx_sync.sv
// HUB75 input stage: resynchronizes the bus and detects rising phy_clk/phy_le.
// Define HUB75_RX_SYNC_EN for a two-flop synchronizer (latency 3 instead of 2).
module hub75_rx_sync
    import hub75_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  sdata_t phy_data_i,
    input  logic   phy_clk_i,
    input  logic   phy_le_i,
    input  row_t   phy_addr_i,
    output sdata_t data_o,
    output row_t   addr_o,
    output logic   shift_o,
    output logic   latch_o
);

    localparam int BW = SDW + LOG_N_ROWS + 2;

    // All bus bits travel together so data/address line up with the strobes.
    logic [BW-1:0] bus_w;
    logic [BW-1:0] stage_q;
    logic [1:0]    prev_q;

    assign bus_w = {phy_clk_i, phy_le_i, phy_addr_i, phy_data_i};

`ifdef HUB75_RX_SYNC_EN
    logic [BW-1:0] meta_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= '0;
            stage_q <= '0;
            prev_q  <= '0;
        end else begin
            meta_q  <= bus_w;
            stage_q <= meta_q;
            prev_q  <= stage_q[BW-1 -: 2];
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
            prev_q  <= '0;
        end else begin
            stage_q <= bus_w;
            prev_q  <= stage_q[BW-1 -: 2];
        end
    end
`endif

    assign data_o  = stage_q[SDW-1:0];
    assign addr_o  = stage_q[SDW +: LOG_N_ROWS];
    assign shift_o = stage_q[BW-1] & ~prev_q[1];
    assign latch_o = stage_q[BW-2] & ~prev_q[0];

endmodule

// File: rtl/hub75_rx.sv
// HUB75 receive front end: deserializes shifted lines into a ping-pong line
// buffer and announces each latched line. Option macro: HUB75_RX_SYNC_EN.
module hub75_rx
    import hub75_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SDW-1:0]          phy_data,
    input  logic                    phy_clk,
    input  logic                    phy_le,
    input  logic [LOG_N_ROWS-1:0]   phy_addr,
    output logic [SDW-1:0]          ram_wr_data,
    output logic [LOG_N_COLS:0]     ram_wr_addr,
    output logic                    ram_wr_en,
    output logic                    line_stb,
    output logic                    line_buf,
    output logic [LOG_N_ROWS-1:0]   line_row,
    output logic [LOG_N_PLANES-1:0] line_plane,
    output logic                    line_err
);

    localparam col_cnt_t COL_END   = col_cnt_t'(N_COLS);
    localparam col_cnt_t COL_ONE   = col_cnt_t'(1);
    localparam plane_t   PLANE_MAX = plane_t'(N_PLANES - 1);
    localparam plane_t   PLANE_ONE = plane_t'(1);

    sdata_t sync_data;
    row_t   sync_addr;
    logic   shift_ev, latch_ev;

    hub75_rx_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .phy_data_i (phy_data),
        .phy_clk_i  (phy_clk),
        .phy_le_i   (phy_le),
        .phy_addr_i (phy_addr),
        .data_o     (sync_data),
        .addr_o     (sync_addr),
        .shift_o    (shift_ev),
        .latch_o    (latch_ev)
    );

    col_cnt_t col_q, col_d;
    logic     ovf_q, ovf_d;
    logic     buf_sel_q, buf_sel_d;
    logic     has_row_q, has_row_d;
    sdata_t   wr_data_q, wr_data_d;
    wr_addr_t wr_addr_q, wr_addr_d;
    logic     wr_en_q, wr_en_d;
    logic     stb_q, stb_d;
    logic     line_buf_q, line_buf_d;
    row_t     line_row_q, line_row_d;
    plane_t   line_plane_q, line_plane_d;
    logic     line_err_q, line_err_d;

    // The shift is applied before the latch so a same-cycle shift counts toward the line.
    always_comb begin
        col_d        = col_q;
        ovf_d        = ovf_q;
        buf_sel_d    = buf_sel_q;
        has_row_d    = has_row_q;
        wr_data_d    = wr_data_q;
        wr_addr_d    = wr_addr_q;
        wr_en_d      = 1'b0;
        stb_d        = 1'b0;
        line_buf_d   = line_buf_q;
        line_row_d   = line_row_q;
        line_plane_d = line_plane_q;
        line_err_d   = line_err_q;

        if (shift_ev) begin
            if (col_q < COL_END) begin
                wr_en_d   = 1'b1;
                wr_data_d = sync_data;
                wr_addr_d = make_wr_addr(buf_sel_q, col_q[LOG_N_COLS-1:0]);
                col_d     = col_q + COL_ONE;
            end else begin
                ovf_d = 1'b1;
            end
        end

        if (latch_ev) begin
            stb_d      = 1'b1;
            line_buf_d = buf_sel_q;
            line_row_d = sync_addr;
            line_err_d = ovf_d | (col_d != COL_END);
            // line_row_q/line_plane_q double as the previously latched row and plane.
            if (!has_row_q || (sync_addr != line_row_q)) begin
                line_plane_d = '0;
            end else if (line_plane_q != PLANE_MAX) begin
                line_plane_d = line_plane_q + PLANE_ONE;
            end
            has_row_d = 1'b1;
            col_d     = '0;
            ovf_d     = 1'b0;
            buf_sel_d = ~buf_sel_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            ovf_q        <= 1'b0;
            buf_sel_q    <= 1'b0;
            has_row_q    <= 1'b0;
            wr_data_q    <= '0;
            wr_addr_q    <= '0;
            wr_en_q      <= 1'b0;
            stb_q        <= 1'b0;
            line_buf_q   <= 1'b0;
            line_row_q   <= '0;
            line_plane_q <= '0;
            line_err_q   <= 1'b0;
        end else begin
            col_q        <= col_d;
            ovf_q        <= ovf_d;
            buf_sel_q    <= buf_sel_d;
            has_row_q    <= has_row_d;
            wr_data_q    <= wr_data_d;
            wr_addr_q    <= wr_addr_d;
            wr_en_q      <= wr_en_d;
            stb_q        <= stb_d;
            line_buf_q   <= line_buf_d;
            line_row_q   <= line_row_d;
            line_plane_q <= line_plane_d;
            line_err_q   <= line_err_d;
        end
    end

    assign ram_wr_data = wr_data_q;
    assign ram_wr_addr = wr_addr_q;
    assign ram_wr_en   = wr_en_q;
    assign line_stb    = stb_q;
    assign line_buf    = line_buf_q;
    assign line_row    = line_row_q;
    assign line_plane  = line_plane_q;
    assign line_err    = line_err_q;

endmodule
